// File: rtl/montgomery_modexp_ctrl.sv
// ---------------------------------------------------------------------------
// montgomery_modexp_ctrl
//
// Left-to-right square-and-multiply sequencer for result = x^e mod m. It
// does no arithmetic of its own. It issues one Montgomery multiplication at a
// time to an external multiplier and keeps the running accumulator A.
//
// Call sequence:
//   TOMONT   : X~ = x * R^2 * R^-1         (base into Montgomery form)
//   SQUARE   : A  = A * A * R^-1           (once per exponent bit)
//   MULT     : A  = A * X~ * R^-1          (only when e[i] = 1)
//   FROMMONT : result = A * 1 * R^-1       (back to normal form)
// A starts as R mod m, which is the Montgomery form of 1.
//
// Optional build macro: MODEXP_CONST_TIME_EN
//   When defined, MULT is issued after every SQUARE. Its result is discarded
//   when e[i] = 0, so the number of calls does not depend on the exponent.
//
// Ports:
//   clk, resetn        clock (rising edge) and asynchronous active-low reset
//   start              one-cycle request, only sampled while idle
//   in_x, in_e, e_len  base, exponent, number of exponent bits to process
//   in_m, in_r2, in_r  odd modulus, R^2 mod m, R mod m (R = 2^WIDTH)
//   mm_start           one-cycle start pulse to the multiplier
//   mm_a, mm_b, mm_m   multiplier operands, held until mm_done is taken
//   mm_result, mm_done multiplier product a*b*R^-1 mod m and its completion
//   busy               high while an exponentiation is in progress
//   done               one-cycle completion pulse
//   result             x^e mod m, valid with done, held afterwards
// ---------------------------------------------------------------------------
module montgomery_modexp_ctrl #(
    parameter int WIDTH   = 1024,
    parameter int E_WIDTH = 1024,
    parameter int LEN_W   = 11
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic [WIDTH-1:0]   in_x,
    input  logic [E_WIDTH-1:0] in_e,
    input  logic [LEN_W-1:0]   e_len,
    input  logic [WIDTH-1:0]   in_m,
    input  logic [WIDTH-1:0]   in_r2,
    input  logic [WIDTH-1:0]   in_r,
    output logic               mm_start,
    output logic [WIDTH-1:0]   mm_a,
    output logic [WIDTH-1:0]   mm_b,
    output logic [WIDTH-1:0]   mm_m,
    input  logic [WIDTH-1:0]   mm_result,
    input  logic               mm_done,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result
);

    // Only the low IDX_W bits of the index are needed to address the exponent.
    // An e_len above E_WIDTH is not a supported input.
    localparam int IDX_W = (E_WIDTH > 1) ? $clog2(E_WIDTH) : 1;

    // Each CALL state lasts exactly one cycle, and mm_start is high in it.
    // The WAIT state that follows is the first cycle in which mm_done counts.
    typedef enum logic [3:0] {
        S_IDLE,
        S_TOMONT_CALL,
        S_TOMONT_WAIT,
        S_SQ_CALL,
        S_SQ_WAIT,
        S_MUL_CALL,
        S_MUL_WAIT,
        S_NEXT,
        S_FROM_CALL,
        S_FROM_WAIT,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     x_q, x_d;
    logic [WIDTH-1:0]     r2_q, r2_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic [E_WIDTH-1:0]   e_q, e_d;
    logic [LEN_W-1:0]     elen_q, elen_d;
    logic [LEN_W-1:0]     i_q, i_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     xm_q, xm_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 mm_start_q, mm_start_d;
    logic [WIDTH-1:0]     mm_a_q, mm_a_d;
    logic [WIDTH-1:0]     mm_b_q, mm_b_d;
    logic                 e_bit;

    assign e_bit = e_q[i_q[IDX_W-1:0]];

    // Next-state and datapath logic. The multiplier operands are loaded in
    // the cycle that enters a CALL state, and they are taken from the *next*
    // accumulator value. This lets a WAIT that captures mm_result go
    // straight into the next CALL without an extra cycle.
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        r2_d       = r2_q;
        m_d        = m_q;
        e_d        = e_q;
        elen_d     = elen_q;
        i_d        = i_q;
        a_d        = a_q;
        xm_d       = xm_q;
        result_d   = result_q;
        mm_start_d = 1'b0;
        mm_a_d     = mm_a_q;
        mm_b_d     = mm_b_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x_d     = in_x;
                    r2_d    = in_r2;
                    m_d     = in_m;
                    e_d     = in_e;
                    elen_d  = e_len;
                    a_d     = in_r;
                    i_d     = e_len - LEN_W'(1);
                    state_d = S_TOMONT_CALL;
                end
            end
            S_TOMONT_CALL: state_d = S_TOMONT_WAIT;
            S_TOMONT_WAIT: begin
                if (mm_done) begin
                    xm_d    = mm_result;
                    state_d = (elen_q == '0) ? S_FROM_CALL : S_SQ_CALL;
                end
            end
            S_SQ_CALL: state_d = S_SQ_WAIT;
            S_SQ_WAIT: begin
                if (mm_done) begin
                    a_d = mm_result;
`ifdef MODEXP_CONST_TIME_EN
                    state_d = S_MUL_CALL;
`else
                    state_d = e_bit ? S_MUL_CALL : S_NEXT;
`endif
                end
            end
            S_MUL_CALL: state_d = S_MUL_WAIT;
            S_MUL_WAIT: begin
                if (mm_done) begin
`ifdef MODEXP_CONST_TIME_EN
                    // Dummy multiply for a zero bit: the call happens, the product is dropped.
                    if (e_bit) begin
                        a_d = mm_result;
                    end
`else
                    a_d = mm_result;
`endif
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                // The exit test comes before the decrement, so i never wraps.
                if (i_q == '0) begin
                    state_d = S_FROM_CALL;
                end else begin
                    i_d     = i_q - LEN_W'(1);
                    state_d = S_SQ_CALL;
                end
            end
            S_FROM_CALL: state_d = S_FROM_WAIT;
            S_FROM_WAIT: begin
                if (mm_done) begin
                    result_d = mm_result;
                    state_d  = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        case (state_d)
            S_TOMONT_CALL: begin
                mm_start_d = 1'b1;
                mm_a_d     = x_d;
                mm_b_d     = r2_d;
            end
            S_SQ_CALL: begin
                mm_start_d = 1'b1;
                mm_a_d     = a_d;
                mm_b_d     = a_d;
            end
            S_MUL_CALL: begin
                mm_start_d = 1'b1;
                mm_a_d     = a_d;
                mm_b_d     = xm_d;
            end
            S_FROM_CALL: begin
                mm_start_d = 1'b1;
                mm_a_d     = a_d;
                mm_b_d     = {{(WIDTH-1){1'b0}}, 1'b1};
            end
            default: ;
        endcase
    end

    // State register. Reset clears everything and aborts any call in flight.
    // Because the state returns to IDLE, a late mm_done is simply ignored.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            x_q        <= '0;
            r2_q       <= '0;
            m_q        <= '0;
            e_q        <= '0;
            elen_q     <= '0;
            i_q        <= '0;
            a_q        <= '0;
            xm_q       <= '0;
            result_q   <= '0;
            mm_start_q <= 1'b0;
            mm_a_q     <= '0;
            mm_b_q     <= '0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            r2_q       <= r2_d;
            m_q        <= m_d;
            e_q        <= e_d;
            elen_q     <= elen_d;
            i_q        <= i_d;
            a_q        <= a_d;
            xm_q       <= xm_d;
            result_q   <= result_d;
            mm_start_q <= mm_start_d;
            mm_a_q     <= mm_a_d;
            mm_b_q     <= mm_b_d;
        end
    end

    assign mm_start = mm_start_q;
    assign mm_a     = mm_a_q;
    assign mm_b     = mm_b_q;
    assign mm_m     = m_q;
    assign result   = result_q;
    assign done     = (state_q == S_DONE);
    assign busy     = (state_q != S_IDLE) && (state_q != S_DONE);

endmodule

// File: tb/tb_montgomery_modexp_ctrl.sv
// ---------------------------------------------------------------------------
// tb_montgomery_modexp_ctrl
//
// Self-checking bench for montgomery_modexp_ctrl at full 1024-bit width.
// A behavioural Montgomery multiplier answers the controller's calls. The
// expected values come from plain modular exponentiation ((a*b) % m
// arithmetic) and from a closed-form count of multiplier calls.
// ---------------------------------------------------------------------------
module tb_montgomery_modexp_ctrl;

    localparam int W  = 1024;
    localparam int EW = 1024;
    localparam int LW = 11;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  in_x = '0;
    logic [EW-1:0] in_e = '0;
    logic [LW-1:0] e_len = '0;
    logic [W-1:0]  in_m = '0;
    logic [W-1:0]  in_r2 = '0;
    logic [W-1:0]  in_r = '0;
    logic          mm_start;
    logic [W-1:0]  mm_a, mm_b, mm_m;
    logic [W-1:0]  mm_result = '0;
    logic          mm_done = 1'b0;
    logic          busy, done;
    logic [W-1:0]  result;

    int n_checks = 0;
    int n_fail   = 0;

    // Monotonic counters; tests take differences.
    int mm_calls    = 0;
    int done_pulses = 0;

    // Multiplier model controls.
    bit           zero_lat = 1'b0;
    bit           mdl_busy = 1'b0;
    int           lat_cnt  = 0;
    logic [W-1:0] pend_res = '0;

    always #5 clk = ~clk;

    montgomery_modexp_ctrl #(.WIDTH(W), .E_WIDTH(EW), .LEN_W(LW)) dut (
        .clk(clk), .resetn(resetn), .start(start),
        .in_x(in_x), .in_e(in_e), .e_len(e_len),
        .in_m(in_m), .in_r2(in_r2), .in_r(in_r),
        .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b), .mm_m(mm_m),
        .mm_result(mm_result), .mm_done(mm_done),
        .busy(busy), .done(done), .result(result)
    );

    // a*b*R^-1 mod m by bit-serial reduction (valid for odd m, a,b < m).
    function automatic logic [W-1:0] mont_mul(input logic [W-1:0] a, b, m);
        logic [2*W+1:0] t;
        t = (2*W+2)'(a) * (2*W+2)'(b);
        for (int k = 0; k < W; k++) begin
            if (t[0]) t = t + (2*W+2)'(m);
            t = t >> 1;
        end
        if (t >= (2*W+2)'(m)) t = t - (2*W+2)'(m);
        return t[W-1:0];
    endfunction

    // Reference: x^e mod m with ordinary arithmetic.
    function automatic logic [W-1:0] ref_modexp(input logic [W-1:0] x, input logic [EW-1:0] e,
                                                input int elen, input logic [W-1:0] m);
        logic [2*W-1:0] acc, mm, xx;
        acc = 1;
        mm  = (2*W)'(m);
        xx  = (2*W)'(x);
        for (int k = elen - 1; k >= 0; k--) begin
            acc = (acc * acc) % mm;
            if (e[k]) acc = (acc * xx) % mm;
        end
        return acc[W-1:0];
    endfunction

    function automatic int exp_calls(input logic [EW-1:0] e, input int elen);
        int n;
`ifdef MODEXP_CONST_TIME_EN
        n = 2 + 2 * elen;
`else
        n = 2 + elen;
        for (int k = 0; k < elen; k++) if (e[k]) n++;
`endif
        return n;
    endfunction

    function automatic int budget(input int elen);
        return 20 * (elen + 2) + 40;
    endfunction

    // Behavioural multiplier: result 5 cycles after mm_start. In zero-latency
    // mode mm_done stays high and the product appears right after mm_start.
    always @(posedge clk) begin
        logic [W-1:0] r;
        mm_done <= zero_lat;
        if (mm_start === 1'b1) begin
            r = mont_mul(mm_a, mm_b, mm_m);
            mm_calls = mm_calls + 1;
            if (zero_lat) begin
                mm_result <= r;
            end else begin
                pend_res <= r;
                lat_cnt  <= 5;
                mdl_busy <= 1'b1;
            end
        end else if (mdl_busy) begin
            if (lat_cnt <= 1) begin
                mm_done   <= 1'b1;
                mm_result <= pend_res;
                mdl_busy  <= 1'b0;
            end else begin
                lat_cnt <= lat_cnt - 1;
            end
        end
    end

    always @(negedge clk) if (done === 1'b1) done_pulses++;

    task automatic rand_wide(output logic [W-1:0] v);
        for (int k = 0; k < W / 32; k++) v[k*32 +: 32] = $urandom;
    endtask

    task automatic set_inputs(input logic [W-1:0] x, input logic [EW-1:0] e,
                              input int elen, input logic [W-1:0] m);
        logic [W:0]     rfull;
        logic [W-1:0]   rmod;
        logic [2*W-1:0] r2;
        rfull    = '0;
        rfull[W] = 1'b1;
        rfull    = rfull % (W+1)'(m);
        rmod     = rfull[W-1:0];
        r2       = ((2*W)'(rmod) * (2*W)'(rmod)) % (2*W)'(m);
        in_x  = x;
        in_e  = e;
        e_len = LW'(elen);
        in_m  = m;
        in_r  = rmod;
        in_r2 = r2[W-1:0];
    endtask

    task automatic scramble_inputs();
        in_x  = ~in_x;
        in_e  = ~in_e;
        e_len = ~e_len;
        in_m  = ~in_m;
        in_r  = ~in_r;
        in_r2 = ~in_r2;
    endtask

    task automatic launch(input logic [W-1:0] x, input logic [EW-1:0] e,
                          input int elen, input logic [W-1:0] m);
        @(negedge clk);
        set_inputs(x, e, elen, m);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        scramble_inputs();
    endtask

    task automatic wait_done(input int cycles, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic run_op(input logic [W-1:0] x, input logic [EW-1:0] e, input int elen,
                          input logic [W-1:0] m, output logic [W-1:0] res,
                          output int calls, output bit ok);
        int c0;
        c0 = mm_calls;
        launch(x, e, elen, m);
        wait_done(budget(elen), ok);
        res   = result;
        calls = mm_calls - c0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        start  = 1'b1;
        in_x   = '1;
        in_m   = '1;
        e_len  = '1;
        repeat (2) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy got %0b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done got %0b expected 0", done); end
        n_checks++; if (mm_start !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_mm_start got %0b expected 0", mm_start); end
        n_checks++; if (result !== '0) begin n_fail++; $display("[TB] FAIL reset_result got low128 %h expected 0", result[127:0]); end
        n_checks++; if (mm_a !== '0 || mm_b !== '0) begin n_fail++; $display("[TB] FAIL reset_mm_ab got %h/%h expected 0", mm_a[63:0], mm_b[63:0]); end
        n_checks++; if (mm_m !== '0) begin n_fail++; $display("[TB] FAIL reset_mm_m got %h expected 0", mm_m[63:0]); end
        resetn = 1'b1;
        start  = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (busy !== 1'b0 || mm_m !== '0) begin n_fail++; $display("[TB] FAIL reset_start_ignored busy %0b mm_m %h expected 0/0", busy, mm_m[63:0]); end
    endtask

    task automatic test_scenario1();
        logic [W-1:0] res;
        int calls, d0;
        bit ok;
        d0 = done_pulses;
        run_op(W'(2), EW'('hA), 4, W'(13), res, calls, ok);
        n_checks++; if (!ok) begin n_fail++; $display("[TB] FAIL s1_timeout done not seen within budget"); end
        n_checks++; if (res !== ref_modexp(W'(2), EW'('hA), 4, W'(13))) begin n_fail++; $display("[TB] FAIL s1_result got %0d expected %0d", res[31:0], ref_modexp(W'(2), EW'('hA), 4, W'(13))); end
        n_checks++; if (calls != exp_calls(EW'('hA), 4)) begin n_fail++; $display("[TB] FAIL s1_calls got %0d expected %0d", calls, exp_calls(EW'('hA), 4)); end
        repeat (3) @(negedge clk);
        n_checks++; if (done_pulses - d0 != 1) begin n_fail++; $display("[TB] FAIL s1_done_count got %0d expected 1", done_pulses - d0); end
        n_checks++; if (busy !== 1'b0 || result !== res) begin n_fail++; $display("[TB] FAIL s1_hold busy %0b result %0d expected 0 and %0d", busy, result[31:0], res[31:0]); end
    endtask

    task automatic test_small_exponents();
        logic [W-1:0] res;
        int calls, el;
        bit ok;
        for (el = 1; el >= 0; el--) begin
            run_op(W'(7), EW'(1), el, W'(13), res, calls, ok);
            n_checks++; if (!ok) begin n_fail++; $display("[TB] FAIL small_timeout e_len %0d", el); end
            n_checks++; if (res !== ref_modexp(W'(7), EW'(1), el, W'(13))) begin n_fail++; $display("[TB] FAIL small_result e_len %0d got %0d expected %0d", el, res[31:0], ref_modexp(W'(7), EW'(1), el, W'(13))); end
            n_checks++; if (calls != exp_calls(EW'(1), el)) begin n_fail++; $display("[TB] FAIL small_calls e_len %0d got %0d expected %0d", el, calls, exp_calls(EW'(1), el)); end
        end
    endtask

    task automatic test_random_short();
        logic [W-1:0]  x, m, res;
        logic [EW-1:0] e;
        int calls, el;
        bit ok;
        for (int n = 0; n < 4; n++) begin
            rand_wide(m);
            if (n[0]) m = W'({$urandom, $urandom});
            m[0] = 1'b1;
            m[(n[0] ? 63 : W-1)] = 1'b1;
            rand_wide(x);
            x = x % m;
            rand_wide(e);
            el = $urandom_range(1, 24);
            run_op(x, e, el, m, res, calls, ok);
            n_checks++; if (!ok) begin n_fail++; $display("[TB] FAIL rand%0d_timeout", n); end
            n_checks++; if (res !== ref_modexp(x, e, el, m)) begin n_fail++; $display("[TB] FAIL rand%0d_result got low128 %h expected low128 %h", n, res[127:0], ref_modexp(x, e, el, m) & W'({128{1'b1}})); end
            n_checks++; if (calls != exp_calls(e, el)) begin n_fail++; $display("[TB] FAIL rand%0d_calls got %0d expected %0d", n, calls, exp_calls(e, el)); end
        end
    endtask

    task automatic test_full_width();
        logic [W-1:0]  x, m, expv;
        logic [EW-1:0] e;
        int c0, drops, calls;
        bit ok;
        rand_wide(m);
        m[W-1] = 1'b1;
        m[0]   = 1'b1;
        rand_wide(x);
        x[W-1] = 1'b0;
        rand_wide(e);
        e[EW-1] = 1'b1;
        expv = ref_modexp(x, e, 1024, m);
        c0 = mm_calls;
        drops = 0;
        ok = 1'b0;
        launch(x, e, 1024, m);
        for (int c = 0; c < budget(1024); c++) begin
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            if (busy !== 1'b1) drops++;
            @(negedge clk);
        end
        calls = mm_calls - c0;
        n_checks++; if (!ok) begin n_fail++; $display("[TB] FAIL full_timeout"); end
        n_checks++; if (result !== expv) begin n_fail++; $display("[TB] FAIL full_result got low128 %h expected low128 %h", result[127:0], expv[127:0]); end
        n_checks++; if (drops != 0) begin n_fail++; $display("[TB] FAIL full_busy low cycles got %0d expected 0", drops); end
        n_checks++; if (calls != exp_calls(e, 1024)) begin n_fail++; $display("[TB] FAIL full_calls got %0d expected %0d", calls, exp_calls(e, 1024)); end
    endtask

    task automatic test_start_ignored();
        logic [W-1:0] exp1, exp3;
        int c0;
        bit ok;
        exp1 = ref_modexp(W'(2), EW'('hA), 4, W'(13));
        exp3 = ref_modexp(W'(3), EW'(4), 3, W'(11));
        c0 = mm_calls;
        launch(W'(2), EW'('hA), 4, W'(13));
        for (int c = 0; c < 50 && (mm_calls - c0) < 2; c++) @(negedge clk);
        // First SQUARE is outstanding: a new request must not disturb it.
        set_inputs(W'(5), EW'(3), 2, W'(11));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        scramble_inputs();
        wait_done(budget(4), ok);
        n_checks++; if (!ok) begin n_fail++; $display("[TB] FAIL ign_timeout"); end
        n_checks++; if (result !== exp1) begin n_fail++; $display("[TB] FAIL ign_result got %0d expected %0d", result[31:0], exp1[31:0]); end
        n_checks++; if (mm_calls - c0 != exp_calls(EW'('hA), 4)) begin n_fail++; $display("[TB] FAIL ign_calls got %0d expected %0d", mm_calls - c0, exp_calls(EW'('hA), 4)); end
        // Request during the DONE cycle: dropped.
        set_inputs(W'(3), EW'(5), 3, W'(7));
        start = 1'b1;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0 || result !== exp1) begin n_fail++; $display("[TB] FAIL ign_done_cycle busy %0b result %0d expected 0 and %0d", busy, result[31:0], exp1[31:0]); end
        // Request in the cycle after DONE: accepted.
        set_inputs(W'(3), EW'(4), 3, W'(11));
        @(negedge clk);
        start = 1'b0;
        scramble_inputs();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL ign_accept busy got %0b expected 1", busy); end
        wait_done(budget(3), ok);
        n_checks++; if (!ok || result !== exp3) begin n_fail++; $display("[TB] FAIL ign_next_result got %0d expected %0d (done seen %0b)", result[31:0], exp3[31:0], ok); end
    endtask

    task automatic test_reset_abort();
        logic [W-1:0] res;
        int c0, d0, stray, calls;
        bit ok;
        c0 = mm_calls;
        launch(W'(2), EW'('hA), 4, W'(13));
        for (int c = 0; c < 60 && (mm_calls - c0) < 3; c++) @(negedge clk);
        d0 = done_pulses;
        resetn = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0 || mm_start !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_ctrl busy %0b done %0b mm_start %0b expected 0/0/0", busy, done, mm_start); end
        n_checks++; if (result !== '0) begin n_fail++; $display("[TB] FAIL abort_result got %0d expected 0", result[31:0]); end
        n_checks++; if (mm_a !== '0 || mm_m !== '0) begin n_fail++; $display("[TB] FAIL abort_operands got %h/%h expected 0", mm_a[63:0], mm_m[63:0]); end
        @(negedge clk);
        resetn = 1'b1;
        stray = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (busy !== 1'b0 || mm_start !== 1'b0) stray++;
        end
        n_checks++; if (stray != 0 || done_pulses != d0) begin n_fail++; $display("[TB] FAIL abort_stale active cycles %0d done pulses %0d expected 0/0", stray, done_pulses - d0); end
        n_checks++; if (result !== '0) begin n_fail++; $display("[TB] FAIL abort_stale_result got %0d expected 0", result[31:0]); end
        run_op(W'(2), EW'('hA), 4, W'(13), res, calls, ok);
        n_checks++; if (!ok || res !== ref_modexp(W'(2), EW'('hA), 4, W'(13))) begin n_fail++; $display("[TB] FAIL abort_rerun got %0d expected %0d (done seen %0b)", res[31:0], ref_modexp(W'(2), EW'('hA), 4, W'(13)), ok); end
    endtask

    task automatic test_zero_latency();
        logic [W-1:0]  x, m, res;
        logic [EW-1:0] e;
        int calls;
        bit ok;
        @(negedge clk);
        zero_lat = 1'b1;
        repeat (2) @(negedge clk);
        run_op(W'(2), EW'('hA), 4, W'(13), res, calls, ok);
        n_checks++; if (!ok || res !== ref_modexp(W'(2), EW'('hA), 4, W'(13))) begin n_fail++; $display("[TB] FAIL zl_s1_result got %0d expected %0d (done seen %0b)", res[31:0], ref_modexp(W'(2), EW'('hA), 4, W'(13)), ok); end
        n_checks++; if (calls != exp_calls(EW'('hA), 4)) begin n_fail++; $display("[TB] FAIL zl_s1_calls got %0d expected %0d", calls, exp_calls(EW'('hA), 4)); end
        rand_wide(m);
        m[W-1] = 1'b1;
        m[0]   = 1'b1;
        rand_wide(x);
        x[W-1] = 1'b0;
        rand_wide(e);
        run_op(x, e, 16, m, res, calls, ok);
        n_checks++; if (!ok || res !== ref_modexp(x, e, 16, m)) begin n_fail++; $display("[TB] FAIL zl_rand_result got low128 %h expected low128 %h (done seen %0b)", res[127:0], ref_modexp(x, e, 16, m) & W'({128{1'b1}}), ok); end
        n_checks++; if (calls != exp_calls(e, 16)) begin n_fail++; $display("[TB] FAIL zl_rand_calls got %0d expected %0d", calls, exp_calls(e, 16)); end
        zero_lat = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #900000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_scenario1();
        test_small_exponents();
        test_random_short();
        test_full_width();
        test_start_ignored();
        test_reset_abort();
        test_zero_latency();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/montgomery_modexp_ctrl.md
Name: montgomery_modexp_ctrl

Overview:
- Modular-exponentiation sequencer: computes result = x^e mod m by left-to-right square-and-multiply.
- Sits directly upstream of the 1024-bit Montgomery multiplier. It drives the multiplier's start and operands (a, b, m) and consumes its result and done.
- Does no arithmetic itself; it sequences multiplier calls and holds the running accumulator.
- Operands are entered in Montgomery form, and the final value is converted back to normal form.

Parameters:
WIDTH, 1024, operand/modulus width; must equal the multiplier width
E_WIDTH, 1024, exponent register width
LEN_W, 11, width of e_len; must satisfy 2^LEN_W > E_WIDTH

Ports:
clk  in  1  clock, all state on rising edge
resetn  in  1  asynchronous active-low reset
start  in  1  one-cycle request; sampled only in IDLE
in_x  in  WIDTH  base, with in_x < in_m
in_e  in  E_WIDTH  exponent, LSB-aligned
e_len  in  LEN_W  number of exponent bits processed, from bit e_len-1 down to bit 0
in_m  in  WIDTH  odd modulus
in_r2  in  WIDTH  R^2 mod m, with R = 2^WIDTH
in_r  in  WIDTH  R mod m
mm_start  out  1  one-cycle start pulse to multiplier
mm_a  out  WIDTH  multiplier operand a
mm_b  out  WIDTH  multiplier operand b
mm_m  out  WIDTH  multiplier modulus (registered copy of in_m)
mm_result  in  WIDTH  multiplier output a*b*R^-1 mod m
mm_done  in  1  multiplier completion
busy  out  1  high from the cycle after accepted start until done
done  out  1  one-cycle completion pulse
result  out  WIDTH  x^e mod m; valid with done, held until next accepted start

Behaviour:
- Reset (async, resetn=0): state=IDLE; mm_start, busy, done = 0; mm_a, mm_b, mm_m, result and all internal registers = 0.
  - Reset asserted mid-operation aborts immediately.
  - Any later mm_done from the aborted call is ignored (state is IDLE).
- IDLE, start=1:
  - Latch in_x, in_e, e_len, in_m, in_r2 and in_r into internal registers.
  - Set A = in_r, bit index i = e_len-1; busy=1; go to TOMONT.
  - start in any other state is ignored. Inputs may change after the accept cycle.
- Issuing a call: each CALL state drives mm_a and mm_b, pulses mm_start for exactly 1 cycle, then moves to the matching WAIT state.
  - mm_a, mm_b and mm_m stay stable until mm_done is sampled.
  - mm_done is ignored in the mm_start cycle and honoured from the next cycle on.
  - Exactly one call is outstanding at a time.
- TOMONT: a=x, b=r2. On done, X~ = mm_result.
  - If e_len=0, go to FROMMONT; otherwise go to SQUARE.
- SQUARE: a=A, b=A. On done, A = mm_result.
  - If e[i]=1, go to MULT; otherwise go to NEXT.
- MULT: a=A, b=X~. On done, A = mm_result; go to NEXT.
- NEXT (1 cycle):
  - If i=0, go to FROMMONT.
  - Otherwise i = i-1 and go to SQUARE.
  - Index decrement never wraps: i=0 always exits.
- FROMMONT: a=A, b=1. On done, result = mm_result and go to DONE.
- DONE (1 cycle): done=1, busy=0, return to IDLE.
  - A new start is accepted in the cycle after DONE.
- Call count without the optional feature: 2 + e_len + popcount(e[e_len-1:0]).
- e_len > E_WIDTH is not a supported input; the behaviour is unspecified.
- Reset asserted in the same cycle as start: reset wins.

Optional Feature:
Macro: MODEXP_CONST_TIME_EN.
- Defined:
  - After every SQUARE, go to MULT regardless of e[i].
  - When e[i]=0, the MULT result is discarded and A is unchanged.
  - Call count is fixed at 2 + 2*e_len, so timing is independent of the exponent value.
- Undefined: MULT is entered only when e[i]=1, as specified in Behaviour.
- Ports and result values are identical in both builds.

Test Plan:
- Bench environment: a behavioural multiplier model returns mm_result = a*b*R^-1 mod m and asserts mm_done 5 cycles after mm_start.
- Scenario 1: x=2, e=0xA, e_len=4, m=13 (R, R^2 mod 13 precomputed) -> result=10, done once, 8 mm_start pulses (10 with MODEXP_CONST_TIME_EN).
- Scenario 2: x=7, e=1, e_len=1, m=13 -> result=7, 4 calls (4 with MODEXP_CONST_TIME_EN); then e_len=0 -> result=1, 2 calls.
- Scenario 3: full 1024-bit x, e and m from the python vector generator, e_len=1024 -> result equals the expected golden value, and busy stays high throughout.
- Scenario 4: start re-pulsed during SQUARE, then a different start on the DONE cycle -> both ignored, result unchanged. start on the cycle after DONE is accepted.
- Scenario 5: resetn pulled low during the 3rd multiplier call -> busy=done=mm_start=0 and result=0 immediately. The stale mm_done is ignored. A fresh scenario-1 run then gives 10.
- Scenario 6: mm_done held high continuously by the model, with 0-cycle latency -> the controller still waits one cycle after each mm_start, and the result is still correct.
